// File: rtl/fifo_sync_nw.sv
// Single-clock FIFO with parametrised width/depth, occupancy count, almost-empty/full,
// sticky overflow/underflow and selectable read style (standard, registered, show-ahead).
module fifo_sync_nw #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int AE_TH  = 2,
  parameter int AF_TH  = (1 << ADDR_W) - 2,
  parameter bit PEEK   = 1'b0,
  parameter bit OUTREG = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wen,
  input  logic              ren,
  input  logic              clr_err,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              wfull,
  output logic              rempty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AE_V    = (ADDR_W+1)'(AE_TH);
  localparam logic [ADDR_W:0] AF_V    = (ADDR_W+1)'(AF_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr, rd_ptr;
  logic [ADDR_W:0]   wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic              wr_ok, rd_ok;
  logic [DATA_W-1:0] head_word;

  assign wr_ok      = wen && !wfull;
  assign rd_ok      = ren && !rempty;
  assign wr_ptr_nxt = wr_ptr + (ADDR_W+1)'(wr_ok);
  assign rd_ptr_nxt = rd_ptr + (ADDR_W+1)'(rd_ok);
  // Pointer difference carries the wrap MSB, so it spans 0..DEPTH.
  assign count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
  assign head_word  = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[ADDR_W-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      wfull        <= 1'b0;
      rempty       <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      count        <= count_nxt;
      wfull        <= (count_nxt == DEPTH_V);
      rempty       <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_V);
      almost_empty <= (count_nxt <= AE_V);
      // A fresh error in the clearing cycle keeps the flag set.
      overflow     <= (wen && wfull)  || (overflow  && !clr_err);
      underflow    <= (ren && rempty) || (underflow && !clr_err);
    end
  end

  generate
    if (PEEK) begin : g_peek
      logic [DATA_W-1:0] last_p0;

      // Track the visible head so rdata can hold it once the FIFO drains.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_p0 <= '0;
        else if (!rempty) last_p0 <= head_word;
      end

      assign rdata  = rempty ? last_p0 : head_word;
      assign rvalid = !rempty;
    end else if (OUTREG) begin : g_outreg
      logic [DATA_W-1:0] rdata_p0, rdata_p1;
      logic              vld_p0, vld_p1;

      // Stage 0: RAM read at the accepting edge.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_p0 <= '0;
          vld_p0   <= 1'b0;
        end else begin
          vld_p0 <= rd_ok;
          if (rd_ok) rdata_p0 <= head_word;
        end
      end

      // Stage 1: output register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_p1 <= '0;
          vld_p1   <= 1'b0;
        end else begin
          vld_p1 <= vld_p0;
          if (vld_p0) rdata_p1 <= rdata_p0;
        end
      end

      assign rdata  = rdata_p1;
      assign rvalid = vld_p1;
    end else begin : g_plain
      logic [DATA_W-1:0] rdata_p0;
      logic              vld_p0;

      // Stage 0: RAM read at the accepting edge.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_p0 <= '0;
          vld_p0   <= 1'b0;
        end else begin
          vld_p0 <= rd_ok;
          if (rd_ok) rdata_p0 <= head_word;
        end
      end

      assign rdata  = rdata_p0;
      assign rvalid = vld_p0;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_nw.sv
// Bench for fifo_sync_nw: three variants (standard, output-registered, show-ahead) share
// one stimulus stream and are checked each cycle against a queue-based model.
module tb_fifo_sync_nw;

  logic        clk;
  logic        rst_n;
  logic [31:0] wdata;
  logic        wen, ren, clr_err;

  logic [31:0] rdata_a, rdata_b, rdata_c;
  logic        rvalid_a, rvalid_b, rvalid_c;
  logic        wfull_a, wfull_b, wfull_c;
  logic        rempty_a, rempty_b, rempty_c;
  logic        af_a, af_b, af_c;
  logic        ae_a, ae_b, ae_c;
  logic [4:0]  count_a, count_b, count_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic        unf_a, unf_b, unf_c;

  int n_vec = 0;
  int n_err = 0;

  fifo_sync_nw #(.DATA_W(32), .ADDR_W(4), .AE_TH(2), .AF_TH(14), .PEEK(1'b0), .OUTREG(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .wdata(wdata), .wen(wen), .ren(ren), .clr_err(clr_err),
    .rdata(rdata_a), .rvalid(rvalid_a), .wfull(wfull_a), .rempty(rempty_a),
    .almost_full(af_a), .almost_empty(ae_a), .count(count_a),
    .overflow(ovf_a), .underflow(unf_a));

  fifo_sync_nw #(.DATA_W(32), .ADDR_W(4), .AE_TH(2), .AF_TH(14), .PEEK(1'b0), .OUTREG(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .wdata(wdata), .wen(wen), .ren(ren), .clr_err(clr_err),
    .rdata(rdata_b), .rvalid(rvalid_b), .wfull(wfull_b), .rempty(rempty_b),
    .almost_full(af_b), .almost_empty(ae_b), .count(count_b),
    .overflow(ovf_b), .underflow(unf_b));

  fifo_sync_nw #(.DATA_W(32), .ADDR_W(4), .AE_TH(2), .AF_TH(14), .PEEK(1'b1), .OUTREG(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .wdata(wdata), .wen(wen), .ren(ren), .clr_err(clr_err),
    .rdata(rdata_c), .rvalid(rvalid_c), .wfull(wfull_c), .rempty(rempty_c),
    .almost_full(af_c), .almost_empty(ae_c), .count(count_c),
    .overflow(ovf_c), .underflow(unf_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of stored words plus the visible read outputs of each variant.
  logic [31:0] q[$];
  bit          m_ovf, m_unf;
  logic [31:0] m_rd_a, m_rd_b, m_pipe, m_last;
  bit          m_rv_a, m_rv_b, m_pv;

  always @(negedge rst_n) begin
    q.delete();
    m_ovf = 0; m_unf = 0;
    m_rd_a = '0; m_rd_b = '0; m_pipe = '0; m_last = '0;
    m_rv_a = 0; m_rv_b = 0; m_pv = 0;
  end

  always @(posedge clk) begin : model
    bit wa, ra;
    logic [31:0] head;
    if (rst_n) begin
      wa   = wen && (q.size() < 16);
      ra   = ren && (q.size() > 0);
      head = ra ? q[0] : 32'h0;
      m_ovf = (wen && q.size() == 16) || (m_ovf && !clr_err);
      m_unf = (ren && q.size() == 0)  || (m_unf && !clr_err);
      // Registered variant shows a popped word one edge later than the standard one.
      m_rv_b = m_pv;
      if (m_pv) m_rd_b = m_pipe;
      m_pv = ra;
      if (ra) m_pipe = head;
      m_rv_a = ra;
      if (ra) begin
        m_rd_a = head;
        m_last = head;
        void'(q.pop_front());
      end
      if (wa) q.push_back(wdata);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("count",        count_a,  q.size());
      chk("wfull",        wfull_a,  q.size() == 16);
      chk("rempty",       rempty_a, q.size() == 0);
      chk("almost_empty", ae_a,     q.size() <= 2);
      chk("almost_full",  af_a,     q.size() >= 14);
      chk("overflow",     ovf_a,    m_ovf);
      chk("underflow",    unf_a,    m_unf);
      chk("rdata_std",    rdata_a,  m_rd_a);
      chk("rvalid_std",   rvalid_a, m_rv_a);
      chk("rdata_oreg",   rdata_b,  m_rd_b);
      chk("rvalid_oreg",  rvalid_b, m_rv_b);
      chk("count_oreg",   count_b,  q.size());
      chk("rdata_peek",   rdata_c,  (q.size() != 0) ? q[0] : m_last);
      chk("rvalid_peek",  rvalid_c, q.size() != 0);
      chk("count_peek",   count_c,  q.size());
    end
  end

  task automatic step(input logic w, input logic [31:0] d, input logic r, input logic c);
    wen = w; wdata = d; ren = r; clr_err = c;
    @(posedge clk);
    #1;
    wen = 1'b0; ren = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    wen = 1'b0; ren = 1'b0; clr_err = 1'b0; wdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    chk("rst_count",  count_a,  0);
    chk("rst_rempty", rempty_a, 1);
    chk("rst_ae",     ae_a,     1);
    chk("rst_wfull",  wfull_a,  0);
    chk("rst_af",     af_a,     0);
    chk("rst_rdata",  rdata_a,  0);
    chk("rst_rvalid", rvalid_a, 0);
    chk("rst_ovf",    ovf_a,    0);
    chk("rst_unf",    unf_a,    0);
    #8 rst_n = 1'b1;

    // Fill, overflow, in-order drain
    for (int i = 1; i <= 16; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
    chk("fill_wfull", wfull_a, 1);
    chk("fill_count", count_a, 16);
    step(1'b1, 32'hDEAD, 1'b0, 1'b0);
    chk("ovf_set",   ovf_a,   1);
    chk("ovf_count", count_a, 16);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("ovf_clr", ovf_a, 0);
    for (int i = 1; i <= 16; i++) begin
      chk("peek_head", rdata_c, 32'(i));
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("drain_rdata",  rdata_a,  32'(i));
      chk("drain_rvalid", rvalid_a, 1);
      if (i >= 2) chk("drain_oreg", rdata_b, 32'(i - 1));
    end
    chk("drain_rempty", rempty_a, 1);

    // Underflow
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("unf_set",   unf_a,   1);
    chk("unf_count", count_a, 0);
    chk("unf_hold",  rdata_a, 32'h10);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("unf_clr", unf_a, 0);

    // Wrap with simultaneous read/write
    for (int i = 0; i < 5; i++) step(1'b1, 32'(100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 32'(200 + i), 1'b1, 1'b0);
      chk("wrap_count", count_a, 5);
    end
    chk("wrap_last", rdata_a, 32'(200 + 34));
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

    // Thresholds
    for (int i = 0; i < 3; i++) step(1'b1, 32'(300 + i), 1'b0, 1'b0);
    chk("ae_at3", ae_a, 0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("ae_at2", ae_a, 1);
    for (int i = 0; i < 11; i++) step(1'b1, 32'(400 + i), 1'b0, 1'b0);
    chk("af_at13", af_a, 0);
    step(1'b1, 32'h500, 1'b0, 1'b0);
    chk("af_at14", af_a, 1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("af_back13", af_a, 0);
    for (int i = 0; i < 13; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("thr_empty", rempty_a, 1);

    // Show-ahead and output-register latency
    step(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
    chk("peek_rempty", rempty_c, 0);
    chk("peek_rdata",  rdata_c,  32'hA5A5A5A5);
    chk("peek_rvalid", rvalid_c, 1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("peek_pop_empty", rempty_c, 1);
    chk("peek_pop_hold",  rdata_c,  32'hA5A5A5A5);
    chk("std_lat1",       rdata_a,  32'hA5A5A5A5);
    chk("oreg_not_yet",   rvalid_b, 0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("oreg_lat2",   rdata_b,  32'hA5A5A5A5);
    chk("oreg_rvalid", rvalid_b, 1);
    chk("std_pulse",   rvalid_a, 0);

    // Randomised traffic with shifting write/read bias
    for (int i = 0; i < 1500; i++) begin
      int pw;
      pw = ((i / 100) % 3 == 0) ? 80 : ((i / 100) % 3 == 1) ? 20 : 50;
      step($urandom_range(99) < pw, $urandom, $urandom_range(99) < (100 - pw),
           $urandom_range(99) < 3);
    end

    // Reset mid-stream
    for (int i = 0; i < 16; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 32'(600 + i), 1'b0, 1'b0);
    chk("pre_rst_count", count_a, 7);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_count",  count_a,  0);
    chk("mid_rst_rempty", rempty_a, 1);
    chk("mid_rst_rdata",  rdata_a,  0);
    chk("mid_rst_peek",   rdata_c,  0);
    chk("mid_rst_ovf",    ovf_a,    0);
    rst_n = 1'b1;
    step(1'b1, 32'h55, 1'b0, 1'b0);
    chk("post_rst_peek", rdata_c, 32'h55);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("post_rst_rdata", rdata_a, 32'h55);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
